// File: rtl/ysyx_24080034_regfile_2r1w_sb.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read bypass and a per-entry busy scoreboard.
module ysyx_24080034_regfile_2r1w_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rbusy1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy2,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ready,
  output logic                  any_busy
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam bit ZR   = (ZERO_REG != 0);
  localparam bit BP   = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;

  logic wr_eff;
  logic rsv_eff;
  logic byp1;
  logic byp2;

  // writes and reservations aimed at a hardwired-zero entry are dropped here
  assign wr_eff    = wen && !(ZR && (waddr == '0));
  assign rsv_ready = !busy[rsv_addr] || (wen && (waddr == rsv_addr));
  assign rsv_eff   = rsv_valid && rsv_ready && !(ZR && (rsv_addr == '0));

  // reserve is applied after release so a same-index collision leaves the entry busy
  always_comb begin
    busy_nxt = busy;
    if (wr_eff) busy_nxt[waddr] = 1'b0;
    if (rsv_eff) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (wr_eff) rf[waddr] <= wdata;
    end
  end

  assign byp1 = BP && wr_eff && (waddr == raddr1);
  assign byp2 = BP && wr_eff && (waddr == raddr2);

  always_comb begin
    if (ZR && (raddr1 == '0)) rdata1 = '0;
    else if (byp1)            rdata1 = wdata;
    else                      rdata1 = rf[raddr1];

    if (ZR && (raddr2 == '0)) rdata2 = '0;
    else if (byp2)            rdata2 = wdata;
    else                      rdata2 = rf[raddr2];
  end

  assign rbusy1   = byp1 ? 1'b0 : busy[raddr1];
  assign rbusy2   = byp2 ? 1'b0 : busy[raddr2];
  assign any_busy = |busy;

endmodule

// File: tb/tb_ysyx_24080034_regfile_2r1w_sb.sv
// Scoreboard bench: three register-file configurations driven each cycle, expectations
// from a spec-level array model are queued and compared by a separate monitor.
module tb_ysyx_24080034_regfile_2r1w_sb;

  typedef struct packed {
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        wen;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rv;
    logic [4:0]  rsa;
  } stim_t;

  typedef struct packed {
    logic [1:0]  d;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        b1;
    logic        b2;
    logic        rdy;
    logic        any;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus for configurations A (bypass) and B (no bypass), both with x0 hardwired
  logic [4:0]  ab_raddr1, ab_raddr2, ab_waddr, ab_rsv_addr;
  logic [31:0] ab_wdata;
  logic        ab_wen, ab_rsv_valid;
  logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic        a_rbusy1, a_rbusy2, a_rsv_ready, a_any_busy;
  logic        b_rbusy1, b_rbusy2, b_rsv_ready, b_any_busy;

  // configuration C: 16 x 64-bit, ordinary x0, bypass on
  logic [3:0]  c_raddr1, c_raddr2, c_waddr, c_rsv_addr;
  logic [63:0] c_wdata, c_rdata1, c_rdata2;
  logic        c_wen, c_rsv_valid, c_rbusy1, c_rbusy2, c_rsv_ready, c_any_busy;

  ysyx_24080034_regfile_2r1w_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .raddr1(ab_raddr1), .rdata1(a_rdata1), .rbusy1(a_rbusy1),
    .raddr2(ab_raddr2), .rdata2(a_rdata2), .rbusy2(a_rbusy2),
    .wen(ab_wen), .waddr(ab_waddr), .wdata(ab_wdata),
    .rsv_valid(ab_rsv_valid), .rsv_addr(ab_rsv_addr), .rsv_ready(a_rsv_ready),
    .any_busy(a_any_busy)
  );

  ysyx_24080034_regfile_2r1w_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .raddr1(ab_raddr1), .rdata1(b_rdata1), .rbusy1(b_rbusy1),
    .raddr2(ab_raddr2), .rdata2(b_rdata2), .rbusy2(b_rbusy2),
    .wen(ab_wen), .waddr(ab_waddr), .wdata(ab_wdata),
    .rsv_valid(ab_rsv_valid), .rsv_addr(ab_rsv_addr), .rsv_ready(b_rsv_ready),
    .any_busy(b_any_busy)
  );

  ysyx_24080034_regfile_2r1w_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .BYPASS(1), .ZERO_REG(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .raddr1(c_raddr1), .rdata1(c_rdata1), .rbusy1(c_rbusy1),
    .raddr2(c_raddr2), .rdata2(c_rdata2), .rbusy2(c_rbusy2),
    .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata),
    .rsv_valid(c_rsv_valid), .rsv_addr(c_rsv_addr), .rsv_ready(c_rsv_ready),
    .any_busy(c_any_busy)
  );

  // reference model: index 0=A, 1=B, 2=C
  logic [63:0] m_rf   [3][32];
  bit          m_busy [3][32];

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  stim_t prev_ab, prev_c;
  bit    prev_rst;

  function automatic bit has_zr(int d);  return d != 2; endfunction
  function automatic bit has_byp(int d); return d != 1; endfunction

  function automatic void model_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++) begin
        m_rf[d][i]   = '0;
        m_busy[d][i] = 1'b0;
      end
  endfunction

  function automatic bit write_lands(int d, stim_t s, logic [4:0] a);
    return s.wen && s.wa == a && !(has_zr(d) && s.wa == 0);
  endfunction

  function automatic logic [63:0] m_read(int d, logic [4:0] a, stim_t s);
    if (has_zr(d) && a == 0) return '0;
    if (has_byp(d) && write_lands(d, s, a)) return s.wd;
    return m_rf[d][a];
  endfunction

  function automatic bit m_rbusy(int d, logic [4:0] a, stim_t s);
    if (has_byp(d) && write_lands(d, s, a)) return 1'b0;
    return m_busy[d][a];
  endfunction

  function automatic bit m_ready(int d, stim_t s);
    return !m_busy[d][s.rsa] || (s.wen && s.wa == s.rsa);
  endfunction

  function automatic void apply_edge(int d, stim_t s);
    bit rdy;
    rdy = m_ready(d, s);
    if (s.wen && !(has_zr(d) && s.wa == 0)) begin
      m_rf[d][s.wa]   = s.wd;
      m_busy[d][s.wa] = 1'b0;
    end
    if (s.rv && rdy && !(has_zr(d) && s.rsa == 0)) m_busy[d][s.rsa] = 1'b1;
  endfunction

  function automatic void push_exp(int d, stim_t s);
    exp_t e;
    e.d   = 2'(d);
    e.r1  = m_read(d, s.ra1, s);
    e.r2  = m_read(d, s.ra2, s);
    e.b1  = m_rbusy(d, s.ra1, s);
    e.b2  = m_rbusy(d, s.ra2, s);
    e.rdy = m_ready(d, s);
    e.any = 1'b0;
    for (int i = 0; i < 32; i++) e.any |= m_busy[d][i];
    q.push_back(e);
  endfunction

  function automatic stim_t mk(int ra1, int ra2, bit wen, int wa, logic [63:0] wd, bit rv, int rsa);
    stim_t s;
    s.ra1 = 5'(ra1); s.ra2 = 5'(ra2); s.wen = wen; s.wa = 5'(wa);
    s.wd = wd; s.rv = rv; s.rsa = 5'(rsa);
    return s;
  endfunction

  task automatic step(input stim_t sab, input stim_t sc, input bit rlow);
    @(posedge clk);
    if (prev_rst) begin
      apply_edge(0, prev_ab);
      apply_edge(1, prev_ab);
      apply_edge(2, prev_c);
    end
    #1;
    rst_n = !rlow;
    if (rlow) model_clear();
    ab_raddr1 = sab.ra1; ab_raddr2 = sab.ra2; ab_wen = sab.wen; ab_waddr = sab.wa;
    ab_wdata = sab.wd[31:0]; ab_rsv_valid = sab.rv; ab_rsv_addr = sab.rsa;
    c_raddr1 = sc.ra1[3:0]; c_raddr2 = sc.ra2[3:0]; c_wen = sc.wen; c_waddr = sc.wa[3:0];
    c_wdata = sc.wd; c_rsv_valid = sc.rv; c_rsv_addr = sc.rsa[3:0];
    push_exp(0, sab);
    push_exp(1, sab);
    push_exp(2, sc);
    prev_ab = sab; prev_c = sc; prev_rst = !rlow;
  endtask

  task automatic chk(input string nm, input logic [1:0] d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
    end
  endtask

  // monitor: outputs are combinational, so every queued expectation is due at the next negedge
  initial begin
    exp_t e;
    logic [63:0] r1, r2;
    logic b1, b2, rdy, any;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.d)
          2'd0: begin r1 = {32'b0, a_rdata1}; r2 = {32'b0, a_rdata2};
                      b1 = a_rbusy1; b2 = a_rbusy2; rdy = a_rsv_ready; any = a_any_busy; end
          2'd1: begin r1 = {32'b0, b_rdata1}; r2 = {32'b0, b_rdata2};
                      b1 = b_rbusy1; b2 = b_rbusy2; rdy = b_rsv_ready; any = b_any_busy; end
          default: begin r1 = c_rdata1; r2 = c_rdata2;
                      b1 = c_rbusy1; b2 = c_rbusy2; rdy = c_rsv_ready; any = c_any_busy; end
        endcase
        chk("rdata1", e.d, r1, e.r1);
        chk("rdata2", e.d, r2, e.r2);
        chk("rbusy1", e.d, 64'(b1), 64'(e.b1));
        chk("rbusy2", e.d, 64'(b2), 64'(e.b2));
        chk("rsv_ready", e.d, 64'(rdy), 64'(e.rdy));
        chk("any_busy", e.d, 64'(any), 64'(e.any));
      end
    end
  end

  initial begin
    stim_t idle, sab, sc;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    prev_rst = 1'b0;
    prev_ab = idle; prev_c = idle;
    ab_raddr1 = '0; ab_raddr2 = '0; ab_wen = 0; ab_waddr = '0; ab_wdata = '0;
    ab_rsv_valid = 0; ab_rsv_addr = '0;
    c_raddr1 = '0; c_raddr2 = '0; c_wen = 0; c_waddr = '0; c_wdata = '0;
    c_rsv_valid = 0; c_rsv_addr = '0;
    model_clear();

    step(idle, idle, 1);
    step(idle, idle, 1);
    // reset mid-run after writing x5 and reserving x6
    step(mk(0, 0, 1, 5, 64'hDEAD, 1, 6), idle, 0);
    step(mk(5, 6, 0, 0, 0, 0, 0), idle, 0);
    step(mk(5, 6, 0, 0, 0, 0, 0), idle, 1);
    step(mk(5, 6, 0, 0, 0, 0, 0), idle, 1);
    step(mk(5, 6, 0, 0, 0, 0, 0), idle, 0);
    // zero register
    step(mk(0, 0, 1, 0, 64'hFFFF_FFFF, 1, 0), idle, 0);
    step(mk(0, 0, 0, 0, 0, 0, 0), idle, 0);
    // bypass vs stored value
    step(mk(0, 7, 1, 7, 64'h1234, 0, 0), idle, 0);
    step(mk(7, 7, 0, 0, 0, 0, 0), idle, 0);
    // scoreboard: reserve, WAW stall, release
    step(mk(3, 0, 0, 0, 0, 1, 3), idle, 0);
    step(mk(3, 3, 0, 0, 0, 1, 3), idle, 0);
    step(mk(3, 3, 1, 3, 64'h55, 0, 0), idle, 0);
    step(mk(3, 3, 0, 0, 0, 0, 0), idle, 0);
    // collision: release and re-reserve x9 in one cycle
    step(mk(0, 0, 0, 0, 0, 1, 9), idle, 0);
    step(mk(9, 9, 1, 9, 64'hAA, 1, 9), idle, 0);
    step(mk(9, 9, 0, 0, 0, 0, 0), idle, 0);

    for (int i = 0; i < 10000; i++) begin
      sab = mk($urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 1) == 1),
               $urandom_range(0, 7), {32'b0, $urandom}, ($urandom_range(0, 4) < 2),
               $urandom_range(0, 7));
      sc  = mk($urandom_range(0, 15), $urandom_range(0, 15), ($urandom_range(0, 1) == 1),
               $urandom_range(0, 15), {$urandom, $urandom}, ($urandom_range(0, 4) < 2),
               $urandom_range(0, 15));
      step(sab, sc, (i == 5000));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 2'd0, 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
